bsg_cache_non_blocking_req_arbiter: RTL

- Shares one non-blocking vcache request/response port among num_req_p requesters, for example several link-to-cache adapters or DMA engines.
- Round-robin arbitration over eligible requesters, with one registered output stage toward the cache.
- Requester index is prepended to the cache id; out-of-order responses are steered back to the requester that owns the id.
- Per-requester outstanding limit bounds the cache miss-FIFO share each requester can occupy.

---
 rtl/bsg_cache_non_blocking_pkg.sv | 27 ++
 rtl/bsg_cache_non_blocking_out_counter.sv | 37 +++
 rtl/bsg_cache_non_blocking_req_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_non_blocking_pkg.sv
// Shared opcode enum and packet-width helpers for the non-blocking vcache.
package bsg_cache_non_blocking_pkg;

    localparam int opcode_width_gp = 6;

    typedef enum logic [opcode_width_gp-1:0] {
        LB    = 6'h00,
        LH    = 6'h01,
        LW    = 6'h02,
        LBU   = 6'h04,
        LHU   = 6'h05,
        SB    = 6'h08,
        SH    = 6'h09,
        SW    = 6'h0a,
        TAGST = 6'h10
    } bsg_cache_non_blocking_opcode_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Field order: opcode, id, addr, data, mask.
    function automatic int pkt_width(input int id_w, input int addr_w, input int data_w);
        return opcode_width_gp + id_w + addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/bsg_cache_non_blocking_out_counter.sv
// Per-requester outstanding-request counter with a hard upper limit.
module bsg_cache_non_blocking_out_counter
    import bsg_cache_non_blocking_pkg::*;
#(
    parameter int max_p = 8,
    localparam int width_lp = safe_clog2(max_p + 1)
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic up_i,
    input  logic down_i,
    output logic limit_reached_o,
    output logic zero_o
);

    logic [width_lp-1:0] cnt_r;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_r <= '0;
        end else if (up_i && !down_i) begin
            cnt_r <= cnt_r + 1'b1;
        end else if (down_i && !up_i) begin
            cnt_r <= cnt_r - 1'b1;
        end
    end

    assign limit_reached_o = (cnt_r >= width_lp'(max_p));
    assign zero_o          = (cnt_r == '0);

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(down_i && !up_i && cnt_r == '0));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_ni)
        !(up_i && !down_i && limit_reached_o));

endmodule

// File: rtl/bsg_cache_non_blocking_req_arbiter.sv
// Round-robin sharing of one non-blocking vcache port; ids are tagged with
// the requester index so out-of-order responses can be steered back.
module bsg_cache_non_blocking_req_arbiter
    import bsg_cache_non_blocking_pkg::*;
#(
    parameter int num_req_p    = 4,
    parameter int id_width_p   = 14,
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    parameter int max_out_p    = 8,
    localparam int lg_num_req_lp      = safe_clog2(num_req_p),
    localparam int cache_id_width_lp  = id_width_p + lg_num_req_lp,
    localparam int req_pkt_width_lp   = pkt_width(id_width_p, addr_width_p, data_width_p),
    localparam int cache_pkt_width_lp = pkt_width(cache_id_width_lp, addr_width_p, data_width_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic [num_req_p*req_pkt_width_lp-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]                 req_v_i,
    output logic [num_req_p-1:0]                 req_yumi_o,
    output logic [cache_pkt_width_lp-1:0]        cache_pkt_o,
    output logic                                 cache_v_o,
    input  logic                                 cache_ready_i,
    input  logic [data_width_p-1:0]              cache_data_i,
    input  logic [cache_id_width_lp-1:0]         cache_id_i,
    input  logic                                 cache_v_i,
    output logic                                 cache_yumi_o,
    output logic [num_req_p*data_width_p-1:0]    resp_data_o,
    output logic [num_req_p*id_width_p-1:0]      resp_id_o,
    output logic [num_req_p-1:0]                 resp_v_o,
    input  logic [num_req_p-1:0]                 resp_yumi_i,
    output logic                                 idle_o,
    output logic                                 err_o
);

    typedef struct packed {
        bsg_cache_non_blocking_opcode_e opcode;
        logic [id_width_p-1:0]          id;
        logic [addr_width_p-1:0]        addr;
        logic [data_width_p-1:0]        data;
        logic [data_width_p/8-1:0]      mask;
    } req_pkt_s;

    typedef struct packed {
        bsg_cache_non_blocking_opcode_e opcode;
        logic [cache_id_width_lp-1:0]   id;
        logic [addr_width_p-1:0]        addr;
        logic [data_width_p-1:0]        data;
        logic [data_width_p/8-1:0]      mask;
    } cache_pkt_s;

    req_pkt_s [num_req_p-1:0] req_pkts;
    req_pkt_s                 sel_pkt;
    cache_pkt_s               load_pkt;
    cache_pkt_s               out_pkt_r;
    logic                     out_v_r;
    logic                     err_r;
    logic [lg_num_req_lp-1:0] rr_ptr_r;
    logic [lg_num_req_lp-1:0] grant;
    logic [lg_num_req_lp-1:0] grant_p1;
    logic [lg_num_req_lp:0]   cand;
    logic                     found;
    logic                     grant_v;
    logic                     load_en;
    logic [num_req_p-1:0]     eligible;
    logic [num_req_p-1:0]     limit;
    logic [num_req_p-1:0]     zero;
    logic [num_req_p-1:0]     hit;
    logic                     idx_ok;
    logic [lg_num_req_lp-1:0] idx;

    assign req_pkts = req_pkt_i;
    assign eligible = req_v_i & ~limit;
    assign load_en  = ~out_v_r | cache_ready_i;
    assign grant_v  = |eligible;

    // Rotate the search so it starts at rr_ptr_r and wraps past num_req_p-1.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < num_req_p; k++) begin
            cand = {1'b0, rr_ptr_r} + (lg_num_req_lp+1)'(k);
            if (cand >= (lg_num_req_lp+1)'(num_req_p)) begin
                cand = cand - (lg_num_req_lp+1)'(num_req_p);
            end
            if (!found && eligible[cand[lg_num_req_lp-1:0]]) begin
                found = 1'b1;
                grant = cand[lg_num_req_lp-1:0];
            end
        end
    end

    assign grant_p1 = (grant == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_yumi_o = '0;
        if (grant_v && load_en && reset_ni) begin
            req_yumi_o[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_pkt         = req_pkts[grant];
        load_pkt.opcode = sel_pkt.opcode;
        load_pkt.id     = {grant, sel_pkt.id};
        load_pkt.addr   = sel_pkt.addr;
        load_pkt.data   = sel_pkt.data;
        load_pkt.mask   = sel_pkt.mask;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            out_v_r   <= 1'b0;
            out_pkt_r <= '0;
            rr_ptr_r  <= '0;
            err_r     <= 1'b0;
        end else begin
            if (load_en) begin
                out_v_r <= grant_v;
                if (grant_v) begin
                    out_pkt_r <= load_pkt;
                    rr_ptr_r  <= grant_p1;
                end
            end
            if (cache_v_i && !idx_ok) begin
                err_r <= 1'b1;
            end
        end
    end

    assign cache_v_o   = out_v_r;
    assign cache_pkt_o = out_pkt_r;

    // An index with no matching requester is dropped and flagged.
    assign idx = cache_id_i[cache_id_width_lp-1 -: lg_num_req_lp];

    always_comb begin
        hit = '0;
        for (int i = 0; i < num_req_p; i++) begin
            hit[i] = (idx == lg_num_req_lp'(i));
        end
        idx_ok       = |hit;
        resp_v_o     = hit & {num_req_p{cache_v_i}};
        cache_yumi_o = cache_v_i & (idx_ok ? |(hit & resp_yumi_i) : 1'b1);
    end

    assign resp_data_o = {num_req_p{cache_data_i}};
    assign resp_id_o   = {num_req_p{cache_id_i[id_width_p-1:0]}};

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        bsg_cache_non_blocking_out_counter #(
            .max_p(max_out_p)
        ) u_cnt (
            .clk_i          (clk_i),
            .reset_ni       (reset_ni),
            .up_i           (req_yumi_o[i]),
            .down_i         (resp_v_o[i] & resp_yumi_i[i]),
            .limit_reached_o(limit[i]),
            .zero_o         (zero[i])
        );
    end

    assign idle_o = ~out_v_r & (&zero);
    assign err_o  = err_r;

endmodule
